cobra_run_ctrl: RTL and testbench
=================================

Name: cobra_run_ctrl

Overview:
- Run-control sequencer for the CYBERcobra core.
- Holds the core in reset after power-up or a restart, then gates execution through a clock-enable.
- Supports run, halt, single-step, a PC breakpoint and a retired-instruction counter.
- Sits between board buttons/switches (already debounced to one-cycle pulses) and the core's reset and enable inputs.

Parameters:
- PC_W, 32, width of core program counter and breakpoint address
- CNT_W, 32, width of retired-instruction counter
- RST_CYCLES, 4, cycles core_rst_o is held after reset/restart (min 1)
- CYCLE_LIMIT, 1000, enable-cycle budget before auto-halt (used only with the optional feature)

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous active-low reset
- run_i  input  1  pulse: start/continue execution
- halt_i  input  1  pulse: stop execution
- step_i  input  1  pulse: execute exactly one instruction
- restart_i  input  1  pulse: re-reset core and counters
- bp_en_i  input  1  breakpoint enable
- bp_addr_i  input  PC_W  breakpoint address
- pc_i  input  PC_W  current core PC
- core_rst_o  output  1  active-high reset to core
- core_en_o  output  1  core clock-enable, one instruction per high cycle
- state_o  output  2  0=HOLD, 1=HALT, 2=RUN, 3=STEP
- bp_hit_o  output  1  sticky: halted by breakpoint
- icount_o  output  CNT_W  instructions retired (core_en_o high cycles)

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=HOLD, hold counter=0, core_rst_o=1, core_en_o=0, bp_hit_o=0, icount_o=0, skip flag=0.
- HOLD:
  - core_rst_o=1.
  - Counter increments each cycle; at count RST_CYCLES-1 → HALT (core_rst_o low from the next cycle).
  - run/step/halt pulses received in HOLD are ignored.
- HALT:
  - core_en_o=0.
  - run_i → RUN, sets skip flag.
  - step_i → STEP.
- RUN:
  - core_en_o = !bp_cond || skip, where bp_cond = bp_en_i && (pc_i == bp_addr_i) (combinational).
  - skip clears after the first RUN cycle, so resuming from a breakpoint PC executes that instruction.
  - If bp_cond && !skip: core_en_o=0 this cycle, → HALT next cycle, bp_hit_o set.
  - halt_i → HALT next cycle; core_en_o=0 in the cycle halt_i is seen.
- STEP:
  - core_en_o=1 for exactly one cycle, ignoring breakpoints, then → HALT.
  - Lasts exactly one cycle; no other input affects it except restart_i.
- Input priority when simultaneous:
  - restart_i > halt_i > step_i > run_i.
  - step_i and run_i together in HALT → STEP.
- restart_i, any state (synchronous):
  - → HOLD, counter=0, icount_o=0, bp_hit_o=0, core_en_o=0 that cycle.
- bp_hit_o clears on any transition into RUN or STEP.
- icount_o:
  - Increments on every cycle with core_en_o=1.
  - Saturates at all-ones; no wrap.
- Outputs:
  - state_o, bp_hit_o and icount_o are registered.
  - core_en_o is combinational from state, skip, bp_cond and halt_i/restart_i.
  - core_rst_o is registered, decoded from state.
- Changes to bp_addr_i/bp_en_i take effect in the same cycle.

Optional Feature:
- Macro: COBRA_RUN_CTRL_CYCLE_LIMIT_EN.
- When defined:
  - An internal budget counter counts core_en_o cycles in RUN since the last entry into RUN.
  - When it reaches CYCLE_LIMIT, core_en_o=0 and → HALT.
  - An extra output limit_hit_o (1 bit, registered, sticky) is set; it clears like bp_hit_o.
  - The counter is reset on each RUN entry and on restart.
- When undefined:
  - No budget counter, no limit_hit_o port.
  - RUN continues indefinitely until halt_i, a breakpoint or restart_i.

Test Plan:
- Reset release, idle:
  - core_rst_o=1 for exactly 4 cycles after rst_i rises, then state_o=1, core_en_o=0, icount_o=0.
  - run_i pulsed during HOLD is ignored.
- step_i pulsed 3 times in HALT, spaced 3 cycles apart:
  - three single-cycle core_en_o pulses, icount_o=3, state_o returns to 1 after each.
- Breakpoint:
  - bp_en_i=1, bp_addr_i=0x10, run_i, core PC walks 0,4,8,C,10.
  - core_en_o low in the cycle pc_i=0x10, state_o=1, bp_hit_o=1, icount_o=4.
  - Then run_i: instruction at 0x10 executes (icount_o=5), bp_hit_o=0.
- Simultaneous halt_i and run_i in RUN:
  - → HALT, core_en_o=0 that cycle.
  - restart_i with halt_i: → HOLD, icount_o=0.
- Counter saturation with CNT_W=4:
  - run 20 cycles → icount_o=15, stays 15.
- With COBRA_RUN_CTRL_CYCLE_LIMIT_EN, CYCLE_LIMIT=10:
  - run_i, no breakpoint → exactly 10 core_en_o cycles, state_o=1, limit_hit_o=1.
  - Without the macro, the same stimulus runs until halt_i.

Source files
------------

// File: rtl/cobra_run_ctrl.sv
// cobra_run_ctrl: run-control sequencer for the CYBERcobra core.
// It holds the core in reset after power-up or a restart, then gates execution
// through a one-instruction-per-cycle clock enable. It provides run, halt,
// single-step, a PC breakpoint and a saturating retired-instruction counter.
// Optional feature: define COBRA_RUN_CTRL_CYCLE_LIMIT_EN to add an enable-cycle
// budget per RUN entry. The budget auto-halts the core and sets limit_hit_o.
module cobra_run_ctrl #(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 4,
    parameter int CYCLE_LIMIT = 1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             halt_i,
    input  logic             step_i,
    input  logic             restart_i,
    input  logic             bp_en_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    input  logic [PC_W-1:0]  pc_i,
    output logic             core_rst_o,
    output logic             core_en_o,
    output logic [1:0]       state_o,
    output logic             bp_hit_o,
`ifdef COBRA_RUN_CTRL_CYCLE_LIMIT_EN
    output logic [CNT_W-1:0] icount_o,
    output logic             limit_hit_o
`else
    output logic [CNT_W-1:0] icount_o
`endif
);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_HALT = 2'd1,
        S_RUN  = 2'd2,
        S_STEP = 2'd3
    } state_e;

    localparam int                HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              skip_q, skip_d;
    logic              bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]  icount_q, icount_d;
    logic              core_rst_q;

    logic bp_cond;
    logic bp_stop;
    logic lim_stop;
    logic limit_reached;
    logic enter_exec;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign bp_cond    = bp_en_i && (pc_i == bp_addr_i);
    // A breakpoint stops RUN only when it is not the instruction being resumed from.
    assign bp_stop    = (state_q == S_RUN) && !restart_i && !halt_i && bp_cond && !skip_q;
    assign lim_stop   = (state_q == S_RUN) && !restart_i && !halt_i && !bp_stop && limit_reached;
    // HALT leaves for RUN or STEP; the sticky halt-cause flags clear on this move.
    assign enter_exec = (state_q == S_HALT) && !restart_i && !halt_i && (step_i || run_i);

    // State register plus sequencing flags, retired count and the registered core reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_HOLD;
            hold_q     <= '0;
            skip_q     <= 1'b0;
            bp_hit_q   <= 1'b0;
            icount_q   <= '0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            skip_q     <= skip_d;
            bp_hit_q   <= bp_hit_d;
            icount_q   <= icount_d;
            core_rst_q <= (state_d == S_HOLD);
        end
    end

    // Next-state logic. Priority is restart > halt > step > run.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        skip_d   = skip_q;
        bp_hit_d = bp_hit_q;
        icount_d = core_en_o ? sat_inc(icount_q) : icount_q;
        if (restart_i) begin
            state_d  = S_HOLD;
            hold_d   = '0;
            skip_d   = 1'b0;
            bp_hit_d = 1'b0;
            icount_d = '0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) state_d = S_HALT;
                    else                     hold_d  = hold_q + 1'b1;
                end
                S_HALT: begin
                    if (enter_exec) bp_hit_d = 1'b0;
                    if (halt_i)     state_d = S_HALT;
                    else if (step_i) state_d = S_STEP;
                    else if (run_i) begin
                        state_d = S_RUN;
                        skip_d  = 1'b1;
                    end
                end
                S_RUN: begin
                    skip_d = 1'b0;
                    if (halt_i || bp_stop || lim_stop) state_d = S_HALT;
                    if (bp_stop) bp_hit_d = 1'b1;
                end
                S_STEP:  state_d = S_HALT;
                default: state_d = S_HOLD;
            endcase
        end
    end

    // Core clock enable. It is combinational so that halt/breakpoint/restart gate the same cycle.
    always_comb begin
        core_en_o = 1'b0;
        unique case (state_q)
            S_RUN:   core_en_o = !restart_i && !halt_i && (skip_q || !bp_cond) && !limit_reached;
            S_STEP:  core_en_o = !restart_i;
            default: core_en_o = 1'b0;
        endcase
    end

`ifdef COBRA_RUN_CTRL_CYCLE_LIMIT_EN
    localparam int               BUD_W   = $clog2(CYCLE_LIMIT + 1);
    localparam logic [BUD_W-1:0] BUD_MAX = BUD_W'(CYCLE_LIMIT);

    logic [BUD_W-1:0] bud_q, bud_d;
    logic             lim_q, lim_d;

    assign limit_reached = (state_q == S_RUN) && (bud_q == BUD_MAX);

    // Budget counts enabled RUN cycles and restarts from zero whenever RUN is re-entered.
    always_comb begin
        bud_d = bud_q;
        lim_d = lim_q;
        if (restart_i) begin
            bud_d = '0;
            lim_d = 1'b0;
        end else begin
            if (state_q != S_RUN) bud_d = '0;
            else if (core_en_o)   bud_d = bud_q + 1'b1;
            if (enter_exec) lim_d = 1'b0;
            if (lim_stop)   lim_d = 1'b1;
        end
    end

    // Budget counter and sticky limit flag registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bud_q <= '0;
            lim_q <= 1'b0;
        end else begin
            bud_q <= bud_d;
            lim_q <= lim_d;
        end
    end

    assign limit_hit_o = lim_q;
`else
    // Without the budget feature RUN never times out; the expression is always false.
    assign limit_reached = (CYCLE_LIMIT < 0);
`endif

    assign core_rst_o = core_rst_q;
    assign state_o    = state_q;
    assign bp_hit_o   = bp_hit_q;
    assign icount_o   = icount_q;

endmodule

// File: tb/tb_cobra_run_ctrl.sv
// Bench for cobra_run_ctrl. It runs two instances on shared stimulus: a 32-bit
// counter instance and a 4-bit counter instance for saturation. A behavioural
// model of the run-control rules is checked every cycle, and directed scenarios
// pin the model with literal expectations.
module tb_cobra_run_ctrl;

    localparam int LIM        = 10;
    localparam int RST_CYCLES = 4;
`ifdef COBRA_RUN_CTRL_CYCLE_LIMIT_EN
    localparam bit LIM_ON = 1'b1;
`else
    localparam bit LIM_ON = 1'b0;
`endif

    localparam int M_HOLD = 0;
    localparam int M_HALT = 1;
    localparam int M_RUN  = 2;
    localparam int M_STEP = 3;

    logic        clk_i     = 1'b0;
    logic        rst_i     = 1'b1;
    logic        run_i     = 1'b0;
    logic        halt_i    = 1'b0;
    logic        step_i    = 1'b0;
    logic        restart_i = 1'b0;
    logic        bp_en_i   = 1'b0;
    logic [31:0] bp_addr_i = 32'h0;
    logic [31:0] pc_i      = 32'h0;

    logic        core_rst_a, core_en_a, bp_hit_a;
    logic [1:0]  state_a;
    logic [31:0] icount_a;
    logic        core_rst_b, core_en_b, bp_hit_b;
    logic [1:0]  state_b;
    logic [3:0]  icount_b;
`ifdef COBRA_RUN_CTRL_CYCLE_LIMIT_EN
    logic        limit_hit_a, limit_hit_b;
`endif

    cobra_run_ctrl #(.PC_W(32), .CNT_W(32), .RST_CYCLES(RST_CYCLES), .CYCLE_LIMIT(LIM)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .halt_i(halt_i), .step_i(step_i),
        .restart_i(restart_i), .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .pc_i(pc_i),
        .core_rst_o(core_rst_a), .core_en_o(core_en_a), .state_o(state_a),
        .bp_hit_o(bp_hit_a),
`ifdef COBRA_RUN_CTRL_CYCLE_LIMIT_EN
        .icount_o(icount_a), .limit_hit_o(limit_hit_a)
`else
        .icount_o(icount_a)
`endif
    );

    cobra_run_ctrl #(.PC_W(32), .CNT_W(4), .RST_CYCLES(RST_CYCLES), .CYCLE_LIMIT(LIM)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .halt_i(halt_i), .step_i(step_i),
        .restart_i(restart_i), .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .pc_i(pc_i),
        .core_rst_o(core_rst_b), .core_en_o(core_en_b), .state_o(state_b),
        .bp_hit_o(bp_hit_b),
`ifdef COBRA_RUN_CTRL_CYCLE_LIMIT_EN
        .icount_o(icount_b), .limit_hit_o(limit_hit_b)
`else
        .icount_o(icount_b)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;
    int en_seen = 0;

    // Model state: mode, hold progress, resume-skip, sticky flags, budget, retired count, core PC.
    int          m_mode = M_HOLD;
    int          m_hold = 0;
    bit          m_skip = 1'b0;
    bit          m_bp   = 1'b0;
    bit          m_lim  = 1'b0;
    int          m_bud  = 0;
    longint      m_cnt  = 0;
    logic [31:0] pc_m   = 32'h0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, followed by the model's advance to the next cycle.
    always @(negedge clk_i) begin
        logic   e_en;
        logic   bpc;
        logic   lim_now;
        longint e_cnt_a;
        longint e_cnt_b;
        if (core_en_a) en_seen++;
        if (!rst_i) begin
            chk("rst core_rst", core_rst_a, 1);
            chk("rst core_en", core_en_a, 0);
            chk("rst state", state_a, M_HOLD);
            chk("rst icount", icount_a, 0);
            chk("rst bp_hit", bp_hit_a, 0);
            m_mode = M_HOLD; m_hold = 0; m_skip = 0; m_bp = 0; m_lim = 0; m_bud = 0; m_cnt = 0;
        end else begin
            bpc     = bp_en_i && (pc_i == bp_addr_i);
            lim_now = LIM_ON && (m_bud == LIM);
            e_en    = 1'b0;
            if (m_mode == M_RUN)       e_en = !restart_i && !halt_i && (m_skip || !bpc) && !lim_now;
            else if (m_mode == M_STEP) e_en = !restart_i;
            e_cnt_a = (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt;
            e_cnt_b = (m_cnt > 15) ? 15 : m_cnt;
            chk("core_en", core_en_a, e_en);
            chk("core_en w4", core_en_b, e_en);
            chk("state", state_a, m_mode);
            chk("core_rst", core_rst_a, m_mode == M_HOLD);
            chk("bp_hit", bp_hit_a, m_bp);
            chk("icount", icount_a, e_cnt_a);
            chk("icount w4", icount_b, e_cnt_b);
`ifdef COBRA_RUN_CTRL_CYCLE_LIMIT_EN
            chk("limit_hit", limit_hit_a, m_lim);
`endif
            if (e_en) begin
                m_cnt++;
                pc_m = pc_m + 32'd4;
            end
            if (restart_i) begin
                m_mode = M_HOLD; m_hold = 0; m_skip = 0; m_bp = 0; m_lim = 0; m_bud = 0; m_cnt = 0;
            end else begin
                case (m_mode)
                    M_HOLD: if (m_hold == RST_CYCLES - 1) m_mode = M_HALT; else m_hold++;
                    M_HALT: if (!halt_i) begin
                        if (step_i) begin
                            m_mode = M_STEP; m_bp = 0; m_lim = 0;
                        end else if (run_i) begin
                            m_mode = M_RUN; m_skip = 1; m_bp = 0; m_lim = 0; m_bud = 0;
                        end
                    end
                    M_RUN: begin
                        if (e_en) m_bud++;
                        if (halt_i) m_mode = M_HALT;
                        else if (bpc && !m_skip) begin m_mode = M_HALT; m_bp = 1; end
                        else if (lim_now) begin m_mode = M_HALT; m_lim = 1; end
                        m_skip = 0;
                    end
                    default: m_mode = M_HALT;
                endcase
            end
        end
    end

    task automatic cyc(input bit r, input bit h, input bit s, input bit rs);
        @(posedge clk_i);
        #1;
        run_i = r; halt_i = h; step_i = s; restart_i = rs;
        pc_i  = pc_m;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    initial begin
        int hcount;
        int e0;
        #2 rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        run_i = 1'b1;

        // Reset release: the core reset is held for exactly RST_CYCLES cycles, and run_i is ignored.
        hcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            if (core_rst_a) hcount++;
            cyc(0, 0, 0, 0);
        end
        chk("hold cycles", hcount, 4);
        @(negedge clk_i);
        chk("idle state", state_a, 1);
        chk("idle en", core_en_a, 0);
        chk("idle icount", icount_a, 0);

        // Three single steps spaced three cycles apart.
        e0 = en_seen;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 0);
            idle(2);
        end
        idle(1);
        @(negedge clk_i);
        chk("step pulses", en_seen - e0, 3);
        chk("step icount", icount_a, 3);
        chk("step state", state_a, 1);

        // Breakpoint at 0x10 while PC walks 0,4,8,C,10; then resume past it.
        cyc(0, 0, 0, 1);
        idle(5);
        pc_m = 32'h0; pc_i = 32'h0;
        bp_en_i = 1'b1; bp_addr_i = 32'h10;
        cyc(1, 0, 0, 0);
        idle(5);
        @(negedge clk_i);
        chk("bp pc", pc_i, 32'h10);
        chk("bp cycle en", core_en_a, 0);
        idle(1);
        @(negedge clk_i);
        chk("bp state", state_a, 1);
        chk("bp hit", bp_hit_a, 1);
        chk("bp icount", icount_a, 4);
        cyc(1, 0, 0, 0);
        idle(2);
        @(negedge clk_i);
        chk("resume icount", icount_a, 5);
        chk("resume bp_hit", bp_hit_a, 0);
        chk("resume state", state_a, 2);
        bp_en_i = 1'b0;

        // halt_i together with run_i while running; then restart_i together with halt_i.
        cyc(1, 1, 0, 0);
        @(negedge clk_i);
        chk("halt+run en", core_en_a, 0);
        idle(1);
        @(negedge clk_i);
        chk("halt+run state", state_a, 1);
        cyc(1, 0, 0, 0);
        idle(2);
        cyc(0, 1, 0, 1);
        @(negedge clk_i);
        chk("restart en", core_en_a, 0);
        idle(1);
        @(negedge clk_i);
        chk("restart state", state_a, 0);
        chk("restart icount", icount_a, 0);
        chk("restart core_rst", core_rst_a, 1);

        // A run with no breakpoint: the budget stops it, or it continues until halt_i.
        idle(5);
        e0 = en_seen;
        cyc(1, 0, 0, 0);
        idle(30);
        @(negedge clk_i);
`ifdef COBRA_RUN_CTRL_CYCLE_LIMIT_EN
        chk("limit en cycles", en_seen - e0, 10);
        chk("limit state", state_a, 1);
        chk("limit hit", limit_hit_a, 1);
`else
        chk("unlimited state", state_a, 2);
        cyc(0, 1, 0, 0);
        idle(1);
        @(negedge clk_i);
        chk("unlimited halted", state_a, 1);
`endif

        // The 4-bit counter saturates at 15.
        repeat (3) begin
            cyc(1, 0, 0, 0);
            idle(12);
        end
        @(negedge clk_i);
        chk("sat icount w4", icount_b, 15);
        cyc(0, 1, 0, 0);
        idle(2);
        @(negedge clk_i);
        chk("sat hold w4", icount_b, 15);

        // Randomised traffic with breakpoints, PC jumps and one asynchronous reset.
        cyc(0, 0, 0, 1);
        idle(5);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 rst_i = 1'b0;
                cyc(0, 0, 0, 0);
                rst_i = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) bp_en_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) bp_addr_i = pc_m + 32'(4 * $urandom_range(0, 5));
            if ($urandom_range(0, 49) == 0) pc_m = 32'(4 * $urandom_range(0, 16));
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
